// File: rtl/piso_param.sv
// Parallel-in/serial-out shift transmitter: captures a SIZE-bit word on a load
// handshake and presents it on a registered serial output, one bit per enabled clock.
module piso_param #(
    parameter int unsigned SIZE      = 16,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic            piso_param_port_clk,
    input  logic            piso_param_port_rst,
    input  logic            piso_param_port_en,
    input  logic            piso_param_port_ld,
    input  logic [SIZE-1:0] piso_param_port_p,
    output logic            piso_param_port_so,
    output logic            piso_param_port_rdy,
    output logic            piso_param_port_busy,
    output logic            piso_param_port_done
);

    localparam int unsigned CW = $clog2(SIZE);

    typedef enum logic {StIdle, StShift} state_e;

    state_e          r_state, w_state_d;
    logic [SIZE-1:0] r_shift, w_shift_d;
    logic [CW-1:0]   r_cnt,   w_cnt_d;
    logic            r_so,    w_so_d;
    logic            r_done,  w_done_d;

    always_comb begin
        w_state_d = r_state;
        w_shift_d = r_shift;
        w_cnt_d   = r_cnt;
        w_so_d    = r_so;
        w_done_d  = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (piso_param_port_en && piso_param_port_ld) begin
                    w_state_d = StShift;
                    w_shift_d = piso_param_port_p;
                    w_cnt_d   = CW'(SIZE - 1);
                    w_so_d    = MSB_FIRST ? piso_param_port_p[SIZE-1] : piso_param_port_p[0];
                end
            end
            StShift: begin
                if (piso_param_port_en) begin
                    if (r_cnt != '0) begin
                        // so always mirrors the output end of the register after the shift
                        if (MSB_FIRST) begin
                            w_shift_d = {r_shift[SIZE-2:0], 1'b0};
                            w_so_d    = r_shift[SIZE-2];
                        end else begin
                            w_shift_d = {1'b0, r_shift[SIZE-1:1]};
                            w_so_d    = r_shift[1];
                        end
                        w_cnt_d = r_cnt - CW'(1);
                    end else begin
                        w_state_d = StIdle;
                        w_shift_d = '0;
                        w_so_d    = 1'b0;
                        w_done_d  = 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge piso_param_port_clk) begin
        if (!piso_param_port_rst) begin
            r_state <= StIdle;
            r_shift <= '0;
            r_cnt   <= '0;
            r_so    <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_shift <= w_shift_d;
            r_cnt   <= w_cnt_d;
            r_so    <= w_so_d;
            r_done  <= w_done_d;
        end
    end

    assign piso_param_port_so   = r_so;
    assign piso_param_port_rdy  = (r_state == StIdle);
    assign piso_param_port_busy = (r_state == StShift);
    assign piso_param_port_done = r_done;

endmodule

// File: tb/tb_piso_param.sv
// Bench for piso_param: a 16-bit MSB-first and an 8-bit LSB-first instance, each checked
// every cycle against a word/bit-index model plus a receiver model rebuilding the word.
module tb_piso_param;

    logic        clk = 1'b0;
    logic        rst;
    logic        m_en, m_ld, m_so, m_rdy, m_busy, m_done;
    logic [15:0] m_p;
    logic        l_en, l_ld, l_so, l_rdy, l_busy, l_done;
    logic [7:0]  l_p;

    int n_chk = 0;
    int n_err = 0;

    // Model state: busy flag, captured word, index of bit on so, done pulse
    bit          mm_busy = 1'b0, mm_done = 1'b0;
    logic [63:0] mm_word = '0;
    int          mm_pos  = 0;
    bit          lm_busy = 1'b0, lm_done = 1'b0;
    logic [63:0] lm_word = '0;
    int          lm_pos  = 0;
    logic [15:0] m_rx = '0;
    logic [7:0]  l_rx = '0;

    always #5 clk = ~clk;

    piso_param #(.SIZE(16), .MSB_FIRST(1'b1)) u_msb (
        .piso_param_port_clk (clk),
        .piso_param_port_rst (rst),
        .piso_param_port_en  (m_en),
        .piso_param_port_ld  (m_ld),
        .piso_param_port_p   (m_p),
        .piso_param_port_so  (m_so),
        .piso_param_port_rdy (m_rdy),
        .piso_param_port_busy(m_busy),
        .piso_param_port_done(m_done)
    );

    piso_param #(.SIZE(8), .MSB_FIRST(1'b0)) u_lsb (
        .piso_param_port_clk (clk),
        .piso_param_port_rst (rst),
        .piso_param_port_en  (l_en),
        .piso_param_port_ld  (l_ld),
        .piso_param_port_p   (l_p),
        .piso_param_port_so  (l_so),
        .piso_param_port_rdy (l_rdy),
        .piso_param_port_busy(l_busy),
        .piso_param_port_done(l_done)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input logic r, input logic en, input logic ld,
                              input logic [63:0] p, input int size,
                              inout bit busy, inout logic [63:0] word,
                              inout int pos, inout bit done);
        if (!r) begin
            busy = 1'b0; word = '0; pos = 0; done = 1'b0;
        end else begin
            done = 1'b0;
            if (!busy) begin
                if (en && ld) begin
                    busy = 1'b1; word = p; pos = 0;
                end
            end else if (en) begin
                if (pos == size - 1) begin
                    busy = 1'b0; done = 1'b1;
                end else begin
                    pos++;
                end
            end
        end
    endtask

    function automatic logic exp_so(input bit busy, input logic [63:0] word, input int pos,
                                    input int size, input bit msb);
        if (!busy) return 1'b0;
        return msb ? word[size-1-pos] : word[pos];
    endfunction

    // One clock: advance models with the applied inputs, then check both instances.
    task automatic tick();
        logic m_so_pre, l_so_pre, m_en_pre, l_en_pre;
        m_so_pre = m_so; l_so_pre = l_so; m_en_pre = m_en; l_en_pre = l_en;
        model_step(rst, m_en, m_ld, 64'(m_p), 16, mm_busy, mm_word, mm_pos, mm_done);
        model_step(rst, l_en, l_ld, 64'(l_p), 8, lm_busy, lm_word, lm_pos, lm_done);
        @(posedge clk);
        #1;
        if (m_en_pre) m_rx = {m_rx[14:0], m_so_pre};
        if (l_en_pre) l_rx = {l_so_pre, l_rx[7:1]};
        chk("m_so",   m_so,   exp_so(mm_busy, mm_word, mm_pos, 16, 1'b1));
        chk("m_busy", m_busy, mm_busy);
        chk("m_rdy",  m_rdy,  !mm_busy);
        chk("m_done", m_done, mm_done);
        chk("l_so",   l_so,   exp_so(lm_busy, lm_word, lm_pos, 8, 1'b0));
        chk("l_busy", l_busy, lm_busy);
        chk("l_rdy",  l_rdy,  !lm_busy);
        chk("l_done", l_done, lm_done);
        if (mm_done) chk("m_rx", m_rx, mm_word[15:0]);
        if (lm_done) chk("l_rx", l_rx, lm_word[7:0]);
    endtask

    task automatic m_word(input logic [15:0] w);
        int n;
        m_ld = 1'b1; m_p = w;
        tick();
        n = 1;
        m_ld = 1'b0;
        while (!m_done && n < 100) begin
            tick();
            n++;
        end
        chk("m_done_latency", n, 17);
    endtask

    initial begin
        logic [15:0] seq;
        logic [7:0]  lseq;
        int          n;
        int          words;
        int          cyc;

        // Reset held with a pending load
        rst = 1'b0; m_en = 1'b1; m_ld = 1'b1; m_p = 16'hFFFF;
        l_en = 1'b1; l_ld = 1'b1; l_p = 8'hFF;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("rst_so", m_so, 1'b0);
            chk("rst_rdy", m_rdy, 1'b1);
        end
        rst = 1'b1; m_ld = 1'b0; l_ld = 1'b0;
        tick();

        // Basic word
        m_ld = 1'b1; m_p = 16'hA5C3;
        tick();
        m_ld = 1'b0; m_p = 16'h0000;
        seq = '0;
        for (int k = 0; k < 16; k++) begin
            seq = {seq[14:0], m_so};
            chk("basic_busy", m_busy, 1'b1);
            tick();
        end
        chk("basic_seq", seq, 16'b1010_0101_1100_0011);
        chk("basic_done", m_done, 1'b1);
        chk("basic_rdy", m_rdy, 1'b1);

        // Stall after bit 3 with an ignored load in the middle
        m_ld = 1'b1; m_p = 16'h8001;
        tick();
        m_ld = 1'b0;
        for (int k = 0; k < 3; k++) tick();
        chk("stall_bit3", m_so, 1'b0);
        m_en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            m_ld = (k == 2); m_p = (k == 2) ? 16'hFFFF : 16'h0000;
            tick();
            chk("stall_hold", m_so, 1'b0);
        end
        m_ld = 1'b1; m_p = 16'hFFFF;
        m_en = 1'b1;
        tick();
        m_ld = 1'b0;
        n = 1;
        while (!m_done && n < 100) begin
            tick();
            n++;
        end
        chk("stall_done_latency", n, 13);

        // Reset in the middle of a word
        m_ld = 1'b1; m_p = 16'hFFFF;
        tick();
        m_ld = 1'b0;
        for (int k = 0; k < 7; k++) tick();
        chk("mid_bit7", m_so, 1'b1);
        rst = 1'b0;
        tick();
        chk("mid_rst_so", m_so, 1'b0);
        chk("mid_rst_busy", m_busy, 1'b0);
        chk("mid_rst_done", m_done, 1'b0);
        rst = 1'b1;
        tick();
        chk("mid_rst_nodone", m_done, 1'b0);
        m_word(16'h0001);
        tick();

        // Loopback words
        m_word(16'h0000);
        m_word(16'hFFFF);
        m_word(16'h5A5A);
        tick();

        // LSB-first back-to-back
        l_ld = 1'b1; l_p = 8'h35;
        tick();
        l_p = 8'hC6;
        lseq = '0;
        for (int k = 0; k < 8; k++) begin
            lseq = {lseq[6:0], l_so};
            tick();
        end
        chk("lsb_seq", lseq, 8'b1010_1100);
        chk("lsb_done", l_done, 1'b1);
        chk("lsb_gap_so", l_so, 1'b0);
        tick();
        chk("lsb_b2b_busy", l_busy, 1'b1);

        // Random words with random enable and load
        words = 0;
        cyc = 0;
        while (words < 1000 && cyc < 40000) begin
            l_en = ($urandom_range(0, 7) != 0);
            l_ld = $urandom_range(0, 1) == 1;
            l_p  = 8'($urandom);
            tick();
            cyc++;
            if (lm_done) words++;
        end
        chk("random_words", words, 1000);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/piso_param.md
Name: piso_param

Overview:
- Parameterised parallel-in/serial-out shift transmitter. It is the sending end for the team's serial-in/parallel-out register `dff_param`.
- A SIZE-bit word is captured on a load handshake and shifted out one bit per enabled clock. Handshake outputs are ready, busy and a done pulse.
- It sits upstream of a SIPO receiver. `so` drives the receiver's serial input, and both blocks share the same clock and enable.

Parameters:
- SIZE, 16, word width in bits; legal range 2..64.
- MSB_FIRST, 1, 1 = bit SIZE-1 is transmitted first; 0 = bit 0 is transmitted first.

Ports:
- piso_param_port_clk  input  1  single clock; all state updates on the rising edge.
- piso_param_port_rst  input  1  synchronous, active-low reset (0 = reset, sampled on the rising clock edge).
- piso_param_port_en  input  1  shift/accept enable; 0 freezes all state except the done pulse.
- piso_param_port_ld  input  1  load request; qualified by rdy and en.
- piso_param_port_p  input  SIZE  parallel word, sampled only on an accepted load.
- piso_param_port_so  output  1  serial data out, registered.
- piso_param_port_rdy  output  1  block idle; a load is accepted this cycle if ld=1 and en=1.
- piso_param_port_busy  output  1  shift in progress.
- piso_param_port_done  output  1  one-cycle pulse after the last bit has been presented.

Behaviour:
- All outputs are registered. There are no combinational paths from inputs to outputs.
- Reset (rst=0 at an edge), irrespective of en or state:
  - state=IDLE, shift register=0, counter=0.
  - so=0, rdy=1, busy=0, done=0.
  - Reset asserted mid-shift aborts the word. No done is issued.
- State machine has two states, IDLE and SHIFT.
- IDLE:
  - rdy=1, busy=0, so=0.
  - Accept occurs when ld=1 and en=1 at an edge:
    - capture p;
    - counter = SIZE-1;
    - so = first bit (p[SIZE-1] if MSB_FIRST, else p[0]);
    - go to SHIFT.
  - ld with en=0 is ignored. p is don't-care when not accepted.
- SHIFT:
  - rdy=0, busy=1. so shows the current bit.
  - en=1 at an edge with counter>0: shift the register one position toward the output end, so = next bit, counter-1.
  - en=1 at an edge with counter==0: the last bit is finished. Go to IDLE, so=0, done=1.
  - en=0: hold the register, counter, so and state.
  - ld is ignored while busy.
- Timing with en held at 1, load accepted at edge 0:
  - bit k is on so during cycle k+1, for k=0..SIZE-1;
  - done=1 and rdy=1 during cycle SIZE+1.
- done:
  - high for exactly one cycle and cleared at the next edge, even if en=0;
  - never asserted by reset or an ignored ld.
- Back-to-back words: ld=1 during the done cycle is accepted. There is exactly one idle cycle with so=0 between words.
- Counter width is $clog2(SIZE). There is no wrap-around: the counter never decrements below 0. The shift-in fill value is 0.
- busy and rdy are always complementary.

Test Plan:
- Basic word, SIZE=16, MSB_FIRST=1, en=1: load 16'hA5C3 at edge 0 -> so = 1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1 in cycles 1..16; done=1 and rdy=1 only in cycle 17; busy=1 in cycles 1..16.
- Reset: hold rst=0 for 10 cycles with ld=1 and p=16'hFFFF -> so=0, rdy=1, busy=0, done=0 throughout. After release, the first accepted load behaves as in the basic-word case.
- Stall and ignored load: load 16'h8001, drop en for 5 cycles after bit 3 -> so holds bit 3 (0) for 5 extra cycles and done is delayed by 5 cycles. Pulse ld with p=16'hFFFF mid-word -> ignored, so stream unchanged.
- Reset mid-operation: rst=0 at bit 7 of 16'hFFFF -> next cycle so=0, busy=0, rdy=1, no done pulse. A following load of 16'h0001 transmits correctly.
- Back-to-back with LSB_FIRST, SIZE=8, MSB_FIRST=0:
  - load 8'h35, then ld=1 held high;
  - first word: so = 1,0,1,0,1,1,0,0 in cycles 1..8;
  - cycle 9: done=1, so=0, second load accepted;
  - second word starts in cycle 10;
  - 1000 random words are checked against a bench SIPO model reconstructing p.
- Loopback: so feeds the serial input of a SIZE=16 `dff_param`, with shared clock and enable and MSB_FIRST chosen to match the receiver's shift direction -> receiver parallel output equals the loaded word in the cycle done is asserted, for 16'h0000, 16'hFFFF and 16'h5A5A.
